instr_decode_stage: RTL and testbench

//  Decode/issue stage directly upstream of the ALU control stage. Accepts 32-bit instruction words

---
 rtl/instr_decode_stage.sv | 99 +++++++++
 tb/tb_instr_decode_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decode/issue stage with register scoreboard; DECODE_ILLEGAL_TRAP_EN drops and flags illegal opcodes
module instr_decode_stage #(
    parameter int          NREG    = 16,
    parameter int          PC_W    = 8,
    parameter logic [15:0] WR_MASK = 16'h01FF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [3:0]      ex_condition,
    output logic [3:0]      ex_opcode,
    output logic            ex_s,
    output logic [2:0]      ex_shift,
    output logic [3:0]      ex_rd,
    output logic [15:0]     ex_immediate,
    output logic [3:0]      ex_rs1,
    output logic [3:0]      ex_rs2,
    output logic [PC_W-1:0] ex_pc,
    input  logic            wb_valid,
    input  logic [3:0]      wb_rd,
    input  logic            flush,
    output logic            hazard_stall,
    output logic            illegal_instr
);
    logic [3:0] op, rd, rs1, rs2;
    logic rs1_used, rs2_used, wr, hazard, accept, drop;
    logic [NREG-1:0] busy, busy_eff, busy_nxt, wb_mask;

    assign op  = if_instr[27:24];
    assign rd  = if_instr[19:16];
    assign rs1 = if_instr[15:12];
    assign rs2 = if_instr[11:8];
    assign ex_rs1 = ex_immediate[15:12];
    assign ex_rs2 = ex_immediate[11:8];

    assign rs1_used = op <= 4'd5 || op == 4'd8;
    assign rs2_used = op <= 4'd5 || op == 4'd7 || op == 4'd8 || op == 4'd10;
    assign wr       = WR_MASK[op];

    always_comb begin
        wb_mask = '0;
        if (wb_valid) wb_mask[wb_rd] = 1'b1;
        busy_eff = busy & ~wb_mask;
        hazard = (rs1_used && busy_eff[rs1]) || (rs2_used && busy_eff[rs2]) || (wr && busy_eff[rd]);
        if_ready = !reset && !flush && !hazard && (!ex_valid || ex_ready);
        hazard_stall = if_valid && hazard && (!ex_valid || ex_ready);
        accept = if_valid && if_ready;
        busy_nxt = busy_eff;
        // a held instruction squashed before consumption will never write back
        if (flush && ex_valid && !ex_ready && WR_MASK[ex_opcode]) busy_nxt[ex_rd] = 1'b0;
        if (accept && wr && !drop) busy_nxt[rd] = 1'b1;
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic legal;
    assign legal = op <= 4'd8 || op == 4'd10;
    assign drop  = !legal;
    always_ff @(posedge clk) begin
        if (reset) illegal_instr <= 1'b0;
        else illegal_instr <= accept && !legal;
    end
`else
    assign drop = 1'b0;
    assign illegal_instr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_condition <= '0;
            ex_opcode    <= '0;
            ex_s         <= 1'b0;
            ex_shift     <= '0;
            ex_rd        <= '0;
            ex_immediate <= '0;
            ex_pc        <= '0;
            busy         <= '0;
        end else begin
            busy <= busy_nxt;
            if (flush) ex_valid <= 1'b0;
            else if (accept) ex_valid <= !drop;
            else if (ex_ready) ex_valid <= 1'b0;
            if (accept && !drop) begin
                ex_condition <= if_instr[31:28];
                ex_opcode    <= op;
                ex_s         <= if_instr[23];
                ex_shift     <= if_instr[22:20];
                ex_rd        <= rd;
                ex_immediate <= if_instr[15:0];
                ex_pc        <= if_pc;
            end
        end
    end
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed checks of decode, scoreboard stalls, backpressure, flush and illegal opcodes
module tb_instr_decode_stage;
    logic        clk = 1'b0;
    logic        reset, if_valid, if_ready, ex_valid, ex_ready, ex_s;
    logic [31:0] if_instr;
    logic [7:0]  if_pc, ex_pc;
    logic [3:0]  ex_condition, ex_opcode, ex_rd, ex_rs1, ex_rs2, wb_rd;
    logic [2:0]  ex_shift;
    logic [15:0] ex_immediate;
    logic        wb_valid, flush, hazard_stall, illegal_instr;
    int          errors = 0, checks = 0;

    instr_decode_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_condition(ex_condition),
        .ex_opcode(ex_opcode), .ex_s(ex_s), .ex_shift(ex_shift), .ex_rd(ex_rd),
        .ex_immediate(ex_immediate), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .hazard_stall(hazard_stall),
        .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] instr, input logic [7:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        reset = 1'b1; ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = 4'd0; flush = 1'b0;
        present(32'hE0312345, 8'h04);
        tick;
        tick;
        check("rst_if_ready", if_ready, 0);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_opcode", ex_opcode, 0);
        check("rst_pc", ex_pc, 0);
        check("rst_illegal", illegal_instr, 0);

        // decode
        reset = 1'b0;
        #1;
        check("dec_if_ready", if_ready, 1);
        check("dec_no_stall", hazard_stall, 0);
        tick;
        check("dec_valid", ex_valid, 1);
        check("dec_cond", ex_condition, 4'hE);
        check("dec_op", ex_opcode, 4'h0);
        check("dec_s", ex_s, 0);
        check("dec_shift", ex_shift, 3);
        check("dec_rd", ex_rd, 1);
        check("dec_imm", ex_immediate, 16'h2345);
        check("dec_rs1", ex_rs1, 2);
        check("dec_rs2", ex_rs2, 3);
        check("dec_pc", ex_pc, 8'h04);

        // RAW on r1 until writeback
        present(32'hE0041200, 8'h08);
        check("raw_stall", hazard_stall, 1);
        check("raw_not_ready", if_ready, 0);
        tick;
        check("raw_drained", ex_valid, 0);
        check("raw_stall2", hazard_stall, 1);
        wb_valid = 1'b1; wb_rd = 4'd1;
        #1;
        check("raw_wb_ready", if_ready, 1);
        check("raw_wb_nostall", hazard_stall, 0);
        tick;
        wb_valid = 1'b0;
        check("raw_valid", ex_valid, 1);
        check("raw_rd", ex_rd, 4);
        check("raw_pc", ex_pc, 8'h08);

        // backpressure
        ex_ready = 1'b0;
        present(32'hE60500AB, 8'h0C);
        check("bp_not_ready", if_ready, 0);
        check("bp_no_hazard", hazard_stall, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("bp_hold_valid", ex_valid, 1);
            check("bp_hold_rd", ex_rd, 4);
            check("bp_hold_pc", ex_pc, 8'h08);
        end
        ex_ready = 1'b1;
        #1;
        check("bp_release_ready", if_ready, 1);
        tick;
        check("bp_op", ex_opcode, 6);
        check("bp_rd", ex_rd, 5);
        check("bp_imm", ex_immediate, 16'h00AB);
        check("bp_pc", ex_pc, 8'h0C);

        // flush of held MOV r5
        ex_ready = 1'b0; if_valid = 1'b0; flush = 1'b1;
        #1;
        check("fl_not_ready", if_ready, 0);
        tick;
        flush = 1'b0; ex_ready = 1'b1;
        check("fl_valid", ex_valid, 0);
        present(32'hE0065000, 8'h10);
        check("fl_r5_free", hazard_stall, 0);
        check("fl_ready", if_ready, 1);
        tick;
        check("fl_read_valid", ex_valid, 1);
        check("fl_read_rs1", ex_rs1, 5);

        // r4 still busy
        present(32'hE0074000, 8'h14);
        check("r4_stall", hazard_stall, 1);
        wb_valid = 1'b1; wb_rd = 4'd4;
        tick;
        wb_valid = 1'b0;
        check("r4_accepted", ex_rd, 7);

        // illegal opcode B
        present(32'hEB080000, 8'h20);
        check("ill_ready", if_ready, 1);
        tick;
        if_valid = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("ill_valid", ex_valid, 0);
        check("ill_pulse", illegal_instr, 1);
        tick;
        check("ill_pulse_end", illegal_instr, 0);
`else
        check("ill_valid", ex_valid, 1);
        check("ill_op", ex_opcode, 4'hB);
        check("ill_tied", illegal_instr, 0);
`endif

        // illegal op set no busy bit; opcode 6 ignores busy sources
        present(32'hE0098000, 8'h24);
        check("ill_r8_free", hazard_stall, 0);
        tick;
        present(32'hE60A6700, 8'h28);
        check("mov_no_src", hazard_stall, 0);
        tick;
        check("mov_rd", ex_rd, 4'hA);

        // WAW on r6; writeback and re-set in same cycle leaves r6 busy
        present(32'hE0060000, 8'h2C);
        check("waw_stall", hazard_stall, 1);
        wb_valid = 1'b1; wb_rd = 4'd6;
        #1;
        check("waw_wb_ready", if_ready, 1);
        tick;
        wb_valid = 1'b0;
        check("waw_rd", ex_rd, 6);
        present(32'hE00B6000, 8'h30);
        check("set_wins", hazard_stall, 1);

        if_valid = 1'b0;
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
